// File: rtl/mult_arbiter_if.sv
// Bundle between mult_arbiter, its two requesters and the shared multiplier engine.
// slave = arbiter side, master = requesters plus engine.
interface mult_arbiter_if #(
  parameter int unsigned IN_W = 8
);
  logic [1:0]        req;
  logic [IN_W-1:0]   a0;
  logic [IN_W-1:0]   b0;
  logic [IN_W-1:0]   a1;
  logic [IN_W-1:0]   b1;
  logic [1:0]        ack;
  logic [2*IN_W-1:0] result;
  logic              err;
  logic              busy;
  logic              mul_start;
  logic [IN_W-1:0]   mul_multiplier;
  logic [IN_W-1:0]   mul_multiplicand;
  logic [2*IN_W-1:0] mul_product;
  logic              mul_done;

  modport slave (
    input  req, a0, b0, a1, b1, mul_product, mul_done,
    output ack, result, err, busy, mul_start, mul_multiplier, mul_multiplicand
  );

  modport master (
    output req, a0, b0, a1, b1, mul_product, mul_done,
    input  ack, result, err, busy, mul_start, mul_multiplier, mul_multiplicand
  );
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one unsigned shift-add multiplier between two signed requesters.
// Optional MULT_ARB_ZERO_BYPASS_EN answers zero-operand requests without starting the engine.
module mult_arbiter #(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TMR_W   = 8
) (
  input logic           clk,
  input logic           rst,
  mult_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp, StDrain} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic              neg_q, neg_d;
  logic [IN_W-1:0]   mplier_q, mplier_d;
  logic [IN_W-1:0]   mcand_q, mcand_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [2*IN_W-1:0] result_q, result_d;
  logic              err_q, err_d;
`ifdef MULT_ARB_ZERO_BYPASS_EN
  logic              bypass_q, bypass_d;
`endif

  logic              grant_valid;
  logic              grant_sel;
  logic [IN_W-1:0]   sel_a;
  logic [IN_W-1:0]   sel_b;
  logic [2*IN_W-1:0] signed_product;

  // Two's complement negate; the most negative input maps to 2^(IN_W-1), valid as unsigned.
  function automatic logic [IN_W-1:0] mag(input logic [IN_W-1:0] x);
    return x[IN_W-1] ? (~x + {{(IN_W-1){1'b0}}, 1'b1}) : x;
  endfunction

  always_comb begin
    grant_valid = |bus.req;
    unique case (bus.req)
      2'b01:   grant_sel = 1'b0;
      2'b10:   grant_sel = 1'b1;
      2'b11:   grant_sel = ~last_grant_q;
      default: grant_sel = 1'b0;
    endcase
    sel_a = grant_sel ? bus.a1 : bus.a0;
    sel_b = grant_sel ? bus.b1 : bus.b0;
  end

  // Negating a zero product wraps back to zero, so no separate zero check is needed.
  assign signed_product = neg_q ? (~bus.mul_product + {{(2*IN_W-1){1'b0}}, 1'b1})
                                : bus.mul_product;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    neg_d        = neg_q;
    mplier_d     = mplier_q;
    mcand_d      = mcand_q;
    timer_d      = timer_q;
    result_d     = result_q;
    err_d        = err_q;
`ifdef MULT_ARB_ZERO_BYPASS_EN
    bypass_d     = bypass_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          grant_d      = grant_sel;
          last_grant_d = grant_sel;
          mplier_d     = mag(sel_a);
          mcand_d      = mag(sel_b);
          neg_d        = sel_a[IN_W-1] ^ sel_b[IN_W-1];
          timer_d      = '0;
          state_d      = StIssue;
`ifdef MULT_ARB_ZERO_BYPASS_EN
          bypass_d     = 1'b0;
          if ((sel_a == '0) || (sel_b == '0)) begin
            result_d = '0;
            err_d    = 1'b0;
            bypass_d = 1'b1;
            state_d  = StResp;
          end
`endif
        end
      end
      StIssue: begin
        if (bus.mul_done) begin
          result_d = signed_product;
          err_d    = 1'b0;
          state_d  = StResp;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = StResp;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      StResp: begin
        state_d = StDrain;
`ifdef MULT_ARB_ZERO_BYPASS_EN
        if (bypass_q) state_d = StIdle;
`endif
      end
      StDrain: begin
        // Wait for the engine to return to idle before any new start.
        if (!bus.mul_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      neg_q        <= 1'b0;
      mplier_q     <= '0;
      mcand_q      <= '0;
      timer_q      <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
`ifdef MULT_ARB_ZERO_BYPASS_EN
      bypass_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      neg_q        <= neg_d;
      mplier_q     <= mplier_d;
      mcand_q      <= mcand_d;
      timer_q      <= timer_d;
      result_q     <= result_d;
      err_q        <= err_d;
`ifdef MULT_ARB_ZERO_BYPASS_EN
      bypass_q     <= bypass_d;
`endif
    end
  end

  assign bus.ack              = (state_q == StResp) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.result           = result_q;
  assign bus.err              = err_q;
  assign bus.busy             = (state_q != StIdle);
  assign bus.mul_start        = (state_q == StIssue);
  assign bus.mul_multiplier   = mplier_q;
  assign bus.mul_multiplicand = mcand_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: vector table with a scoreboard plus hand-written
// sequences for timeout, mid-operation reset and zero operands.
module tb_mult_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mult_arbiter_if #(.IN_W(8)) bus ();

  mult_arbiter #(.IN_W(8), .TIMEOUT(64), .TMR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Engine model: done rises lat cycles after start, falls once start drops.
  int   eng_lat  = 3;
  logic eng_hang = 1'b0;
  int   eng_cnt;
  logic eng_done_q;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_cnt    <= 0;
      eng_done_q <= 1'b0;
    end else if (bus.mul_start) begin
      if (!eng_hang && (eng_cnt >= eng_lat)) eng_done_q <= 1'b1;
      else eng_cnt <= eng_cnt + 1;
    end else begin
      eng_cnt    <= 0;
      eng_done_q <= 1'b0;
    end
  end

  assign bus.mul_done    = eng_done_q;
  assign bus.mul_product = 16'(bus.mul_multiplier) * 16'(bus.mul_multiplicand);

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  a0, b0, a1, b1;
    logic        hang;
    int          lat;
    logic [15:0] r0, r1;
  } vec_t;

  typedef struct {
    logic [1:0]  ack;
    logic [15:0] result;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  logic lg           = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ack(output logic got);
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.ack != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!bus.busy) begin
        idle = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(name, {31'd0, idle}, 32'd1);
  endtask

  task automatic push(input vec_t v, input int g);
    exp_t e;
    e.ack    = (g == 1) ? 2'b10 : 2'b01;
    e.result = v.hang ? 16'h0000 : ((g == 1) ? v.r1 : v.r0);
    e.err    = v.hang;
    sb.push_back(e);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    exp_t e;
    logic got;
    int   g;
    eng_hang = v.hang;
    eng_lat  = v.lat;
    bus.a0   = v.a0;
    bus.b0   = v.b0;
    bus.a1   = v.a1;
    bus.b1   = v.b1;
    bus.req  = v.req;
    if (v.req == 2'b11) begin
      g = lg ? 0 : 1;
      push(v, g);
      push(v, 1 - g);
      lg = (g == 0);
    end else begin
      g = v.req[1] ? 1 : 0;
      push(v, g);
      lg = (g == 1);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      wait_ack(got);
      if (!got) begin
        check({name, "_ack_timeout"}, 32'd0, 32'd1);
        bus.req = 2'b00;
        continue;
      end
      check({name, "_ack"}, {30'd0, bus.ack}, {30'd0, e.ack});
      check({name, "_result"}, {16'd0, bus.result}, {16'd0, e.result});
      check({name, "_err"}, {31'd0, bus.err}, {31'd0, e.err});
      bus.req = bus.req & ~bus.ack;
    end
    wait_idle({name, "_idle"});
    eng_hang = 1'b0;
  endtask

  vec_t vecs[9];
  vec_t rv;
  logic got;
  int   cnt;
  int   n;

  initial begin
    vecs[0] = '{2'b11, 8'h03, 8'h04, 8'hFB, 8'hFB, 1'b0, 1, 16'h000C, 16'h0019};
    vecs[1] = '{2'b11, 8'h03, 8'h04, 8'hFB, 8'hFB, 1'b0, 5, 16'h000C, 16'h0019};
    vecs[2] = '{2'b01, 8'hF9, 8'h06, 8'h00, 8'h00, 1'b0, 3, 16'hFFD6, 16'h0000};
    vecs[3] = '{2'b01, 8'h80, 8'h80, 8'h00, 8'h00, 1'b0, 2, 16'h4000, 16'h0000};
    vecs[4] = '{2'b10, 8'h00, 8'h00, 8'h80, 8'h01, 1'b0, 4, 16'h0000, 16'hFF80};
    vecs[5] = '{2'b01, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1, 16'h0000, 16'h0000};
    vecs[6] = '{2'b01, 8'h05, 8'h05, 8'h00, 8'h00, 1'b0, 6, 16'h0019, 16'h0000};
    vecs[7] = '{2'b10, 8'h00, 8'h00, 8'h7F, 8'hFF, 1'b0, 2, 16'h0000, 16'hFF81};
    vecs[8] = '{2'b11, 8'hFF, 8'hFF, 8'h0C, 8'hF6, 1'b0, 3, 16'h0001, 16'hFF88};

    bus.req = 2'b00;
    bus.a0  = '0;
    bus.b0  = '0;
    bus.a1  = '0;
    bus.b1  = '0;
    #12;
    check("rst_ack", {30'd0, bus.ack}, 32'd0);
    check("rst_result", {16'd0, bus.result}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_start", {31'd0, bus.mul_start}, 32'd0);
    check("rst_ops", {16'd0, bus.mul_multiplier, bus.mul_multiplicand}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Operand magnitudes to the engine and busy through DRAIN.
    eng_lat = 9;
    bus.a0  = 8'hF9;
    bus.b0  = 8'h06;
    bus.req = 2'b01;
    @(negedge clk);
    check("op_start", {31'd0, bus.mul_start}, 32'd1);
    check("op_mplier", {24'd0, bus.mul_multiplier}, 32'd7);
    check("op_mcand", {24'd0, bus.mul_multiplicand}, 32'd6);
    check("op_busy", {31'd0, bus.busy}, 32'd1);
    wait_ack(got);
    check("op_ack", {30'd0, bus.ack}, 32'd1);
    check("op_result", {16'd0, bus.result}, 32'h0000FFD6);
    bus.req = 2'b00;
    lg = 1'b0;
    @(negedge clk);
    check("op_drain_busy", {31'd0, bus.busy}, 32'd1);
    check("op_drain_ack", {30'd0, bus.ack}, 32'd0);
    @(negedge clk);
    check("op_idle_busy", {31'd0, bus.busy}, 32'd0);
    check("op_hold_result", {16'd0, bus.result}, 32'h0000FFD6);

    // Watchdog: engine never answers, ISSUE lasts exactly TIMEOUT cycles.
    eng_hang = 1'b1;
    bus.a0   = 8'h05;
    bus.b0   = 8'h05;
    bus.req  = 2'b01;
    cnt      = 0;
    got      = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.ack != 2'b00) begin
        got = 1'b1;
        break;
      end
      if (bus.mul_start) cnt++;
    end
    check("to_ack_seen", {31'd0, got}, 32'd1);
    check("to_cycles", cnt, 32'd64);
    check("to_err", {31'd0, bus.err}, 32'd1);
    check("to_result", {16'd0, bus.result}, 32'd0);
    bus.req  = 2'b00;
    eng_hang = 1'b0;
    wait_idle("to_idle");

    // Asynchronous reset in the middle of ISSUE.
    eng_lat = 20;
    bus.a0  = 8'h03;
    bus.b0  = 8'h03;
    bus.req = 2'b01;
    repeat (4) @(negedge clk);
    check("mr_start_before", {31'd0, bus.mul_start}, 32'd1);
    rst = 1'b0;
    #1;
    check("mr_ack", {30'd0, bus.ack}, 32'd0);
    check("mr_busy", {31'd0, bus.busy}, 32'd0);
    check("mr_start", {31'd0, bus.mul_start}, 32'd0);
    check("mr_result_err", {15'd0, bus.result, bus.err}, 32'd0);
    bus.req = 2'b00;
    @(negedge clk);
    check("mr_ack_held", {30'd0, bus.ack}, 32'd0);
    rst = 1'b1;
    lg  = 1'b1;
    @(negedge clk);
    rv = '{2'b10, 8'h00, 8'h00, 8'h02, 8'hFD, 1'b0, 3, 16'h0000, 16'hFFFA};
    run_vec(rv, "after_rst");

    // Zero operand.
    eng_lat = 3;
    bus.a0  = 8'h00;
    bus.b0  = 8'hF7;
    bus.req = 2'b01;
    cnt     = 0;
    n       = 0;
    got     = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (bus.mul_start) cnt++;
      if (bus.ack != 2'b00) begin
        got = 1'b1;
        break;
      end
    end
    check("zero_ack", {30'd0, bus.ack}, 32'd1);
    check("zero_result", {16'd0, bus.result}, 32'd0);
    check("zero_err", {31'd0, bus.err}, 32'd0);
    bus.req = 2'b00;
`ifdef MULT_ARB_ZERO_BYPASS_EN
    check("zero_no_start", cnt, 32'd0);
    check("zero_latency", {31'd0, (n <= 2)}, 32'd1);
    @(negedge clk);
    check("zero_back_idle", {31'd0, bus.busy}, 32'd0);
`else
    check("zero_started", {31'd0, (cnt > 0)}, 32'd1);
`endif
    wait_idle("zero_idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Shares one shift-add sequential multiplier engine between two requesters (e.g. keypad-entry path and self-test path). Arbitrates round-robin, converts signed operands to magnitudes, sequences the engine's start/done handshake, restores the sign on the product and returns it with a one-cycle acknowledge. Includes a watchdog that aborts a hung engine operation. Sits between the requesters and the multiplier engine; the engine's result feeds the BCD conversion and display path.

Parameters:
IN_W, 8, operand width in bits, two's complement.
TIMEOUT, 64, cycles allowed in ISSUE before abort; must be ≥ IN_W+4.
TMR_W, 8, watchdog counter width; must satisfy 2^TMR_W > TIMEOUT.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
req  in  2  per-requester request level; held high with operands stable until ack
a0, b0  in  IN_W each  requester 0 signed operands
a1, b1  in  IN_W each  requester 1 signed operands
ack  out  2  one-hot, one-cycle pulse to the served requester
result  out  2*IN_W  signed product; valid only while ack ≠ 0
err  out  1  high with ack when the operation timed out
busy  out  1  high in any state other than IDLE
mul_start  out  1  engine start, held high until mul_done
mul_multiplier, mul_multiplicand  out  IN_W each  unsigned operand magnitudes to engine
mul_product  in  2*IN_W  engine unsigned product
mul_done  in  1  engine done level

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ack=0, result=0, err=0, busy=0, mul_start=0, operand regs=0, timer=0, last_grant=1 (requester 0 wins the first tie).
- States: IDLE, ISSUE, RESP, DRAIN.
- IDLE: if exactly one req bit is set, grant it. If both are set, grant !last_grant. On grant, in the same edge: latch |a|, |b| and neg = sign(a)^sign(b); set last_grant; clear timer; go to ISSUE. If no req, stay.
- Magnitude: |x| = x<0 ? -x : x, in IN_W unsigned bits. The most negative value (-2^(IN_W-1)) maps to 2^(IN_W-1) and is correct as unsigned.
- ISSUE: mul_start=1 and mul_* driven from the latched regs.
  - On mul_done=1: result <= neg ? -mul_product : mul_product (2*IN_W two's complement), err<=0, go to RESP.
  - Else if timer==TIMEOUT-1: result<=0, err<=1, go to RESP.
  - Else timer++.
- RESP (exactly 1 cycle): ack[g]=1, mul_start=0; go to DRAIN.
- DRAIN: mul_start=0; stay until mul_done=0, then go to IDLE. This ensures the engine has returned to idle before the next start.
- Latency: in the cycle after ack the requester drops req. A req still high in IDLE is treated as a new request.
- req dropped while granted: the operation completes and ack is still pulsed; the requester ignores it.
- No new grant is made while busy. The loser of a tie is served next.
- rst=0 mid-operation aborts immediately with no ack. The engine shares the reset and is reset at the same time.
- Zero-operand products return 0 with err=0; the sign is not applied to zero.
- result and err hold their values outside RESP; ack is 0 outside RESP.

Optional Feature:
MULT_ARB_ZERO_BYPASS_EN
- Defined: in IDLE, if the granted requester's a==0 or b==0, load result=0 and err=0, skip ISSUE and DRAIN, and go IDLE→RESP→IDLE. ack arrives 2 edges after grant and mul_start is never asserted.
- Undefined: zero operands go through the engine like any other operand.

Test Plan:
- req=01, a0=-7, b0=6 → mul_start high with multiplier/multiplicand 7/6; after mul_done, ack=01, result=-42 (16'hFFD6), err=0, then busy drops once mul_done falls.
- req=11 from reset, a0=3,b0=4, a1=-5,b1=-5 → ack=01 with result=12 first, then ack=10 with result=25; repeat req=11 → requester 1 still ordering fair (0 then 1 alternate).
- a0=-128, b0=-128 → result=16384 (16'h4000); a0=-128, b0=1 → result=-128 (16'hFF80).
- Engine model never asserts mul_done → after TIMEOUT=64 ISSUE cycles, ack pulses with err=1, result=0; next request is served normally.
- rst pulled low for 1 cycle mid-ISSUE → all outputs 0 immediately, no ack, state IDLE; a subsequent req=10 with a1=2, b1=-3 → result=-6.
- With MULT_ARB_ZERO_BYPASS_EN: a0=0, b0=-9 → ack 2 edges after grant, result=0, mul_start never high. Without the macro: the engine is started and result=0.
